// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file: default geometry and the
// sweep/run state encoding.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, a same-cycle issue
// wins over the clear, and each read port looks up its target with a bypass mask.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    // Sized to the full address space so out-of-range lookups land on bits that never set.
    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW-1:0]    rd_addr;

    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_d[r] = (run && iss_valid && (iss_rd == AW'(r))) ||
                        (busy_q[r] && !(run && we && (waddr == AW'(r))));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rbusy   = '0;
        rd_addr = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr  = raddr[i*AW +: AW];
            rbusy[i] = run && busy_q[rd_addr] &&
                       !((BYPASS != 0) && we && (waddr == rd_addr));
        end
    end

endmodule

// File: rtl/regfile_sb_multiport.sv
// Multi-read, single-write integer register file with optional write->read bypass,
// a busy scoreboard, and a post-reset sweep that zeroes storage one entry per cycle.
module regfile_sb_multiport
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    output logic                hazard,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd
);

    localparam bit FULL = (NREG == (1 << AW));

    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;
    logic            run;
    logic            w_in_range;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem [NREG];

    assign run   = (state_q == RUN);
    assign ready = run;

    if (FULL) begin : g_w_full
        assign w_in_range = 1'b1;
    end else begin : g_w_part
        assign w_in_range = (waddr < AW'(NREG));
    end

    // The sweep owns the single write port until every entry has been zeroed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            RUN: begin
                if (we && (waddr != '0) && w_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = waddr;
                    mem_wdata = wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic            rd_in_range;
        logic [XLEN-1:0] rd_val;

        assign rd_addr = raddr[i*AW +: AW];

        if (FULL) begin : g_r_full
            assign rd_in_range = 1'b1;
        end else begin : g_r_part
            assign rd_in_range = (rd_addr < AW'(NREG));
        end

        always_comb begin
            rd_val = '0;
            if (run && (rd_addr != '0) && rd_in_range) begin
                if ((BYPASS != 0) && we && (waddr == rd_addr)) begin
                    rd_val = wdata;
                end else begin
                    rd_val = mem[rd_addr];
                end
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd_val;
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .waddr     (waddr),
        .raddr     (raddr),
        .rbusy     (rbusy)
    );

    assign hazard = |rbusy;

endmodule

// File: tb/tb_regfile_sb_multiport.sv
// Scoreboard bench for regfile_sb_multiport: one bypassing and one non-bypassing
// instance share stimulus; expectations are queued and checked on the falling edge.
module tb_regfile_sb_multiport;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2*AW-1:0] raddr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;

    logic          ready_a, ready_b;
    logic [63:0]   rdata_a, rdata_b;
    logic [1:0]    rbusy_a, rbusy_b;
    logic          hazard_a, hazard_b;

    always #5 clk = ~clk;

    regfile_sb_multiport #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a), .raddr(raddr), .rdata(rdata_a),
        .rbusy(rbusy_a), .hazard(hazard_a), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd)
    );

    regfile_sb_multiport #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .raddr(raddr), .rdata(rdata_b),
        .rbusy(rbusy_b), .hazard(hazard_b), .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd)
    );

    typedef enum int {
        K_READY_A, K_READY_B, K_RDATA_A, K_RDATA_B,
        K_RBUSY_A, K_RBUSY_B, K_HAZARD_A, K_HAZARD_B
    } kind_e;

    typedef struct {
        kind_e       kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic apply_stimulus(input logic we_i, input logic [AW-1:0] waddr_i,
                                  input logic [31:0] wdata_i, input logic iss_v_i,
                                  input logic [AW-1:0] iss_rd_i,
                                  input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        we        = we_i;
        waddr     = waddr_i;
        wdata     = wdata_i;
        iss_valid = iss_v_i;
        iss_rd    = iss_rd_i;
        raddr     = {ra1, ra0};
    endtask

    task automatic push_exp(input kind_e kind, input int port, input logic [31:0] v,
                            input string name);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drains every expectation queued for this cycle at the falling edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_READY_A:  act = {31'b0, ready_a};
                K_READY_B:  act = {31'b0, ready_b};
                K_RDATA_A:  act = rdata_a[e.port*32 +: 32];
                K_RDATA_B:  act = rdata_b[e.port*32 +: 32];
                K_RBUSY_A:  act = {31'b0, rbusy_a[e.port]};
                K_RBUSY_B:  act = {31'b0, rbusy_b[e.port]};
                K_HAZARD_A: act = {31'b0, hazard_a};
                default:    act = {31'b0, hazard_b};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got 0x%h, expected 0x%h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        repeat (2) tick();
        push_exp(K_READY_A, 0, 32'd0, "ready_in_reset");
        push_exp(K_RDATA_A, 0, 32'd0, "rdata_in_reset");
        tick();
        rst = 1'b0;

        // Sweep: writes and issues during INIT must be ignored.
        for (int n = 0; n < 32; n++) begin
            apply_stimulus(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd5, 5'd6);
            push_exp(K_READY_A, 0, 32'd0, $sformatf("ready_init_%0d", n));
            if (n % 8 == 0) begin
                push_exp(K_READY_B, 0, 32'd0, $sformatf("ready_b_init_%0d", n));
                push_exp(K_RDATA_A, 0, 32'd0, $sformatf("rdata0_init_%0d", n));
                push_exp(K_RBUSY_A, 1, 32'd0, $sformatf("rbusy1_init_%0d", n));
            end
            tick();
        end

        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd6);
        push_exp(K_READY_A, 0, 32'd1, "ready_run");
        push_exp(K_READY_B, 0, 32'd1, "ready_b_run");
        push_exp(K_RDATA_A, 0, 32'd0, "x5_after_init_write");
        push_exp(K_RBUSY_A, 1, 32'd0, "x6_busy_after_init_issue");
        push_exp(K_HAZARD_A, 0, 32'd0, "hazard_after_init");
        tick();

        for (int r = 0; r < 16; r++) begin
            apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'(r), 5'(r + 16));
            push_exp(K_RDATA_A, 0, 32'd0, $sformatf("zero_x%0d", r));
            push_exp(K_RDATA_A, 1, 32'd0, $sformatf("zero_x%0d", r + 16));
            tick();
        end

        // Plain write, and a write to x0 that must be dropped.
        apply_stimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, 5'd1, 5'd2);
        tick();
        apply_stimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, 5'd1, 5'd2);
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd0);
        push_exp(K_RDATA_A, 0, 32'hDEAD_BEEF, "x5_written");
        push_exp(K_RDATA_A, 1, 32'd0, "x0_hardwired");
        push_exp(K_RDATA_B, 0, 32'hDEAD_BEEF, "x5_written_b");
        push_exp(K_RDATA_B, 1, 32'd0, "x0_hardwired_b");
        tick();

        // Same-cycle write/read on x7 with and without bypass.
        apply_stimulus(1'b1, 5'd7, 32'h1111_1111, 1'b0, '0, 5'd1, 5'd2);
        tick();
        apply_stimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, 5'd7, 5'd2);
        push_exp(K_RDATA_A, 0, 32'hA5A5_A5A5, "x7_bypass");
        push_exp(K_RDATA_B, 0, 32'h1111_1111, "x7_no_bypass_old");
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd2);
        push_exp(K_RDATA_A, 0, 32'hA5A5_A5A5, "x7_after_write");
        push_exp(K_RDATA_B, 0, 32'hA5A5_A5A5, "x7_after_write_b");
        tick();

        // Busy set by issue, visible next cycle, masked by bypassed writeback.
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd9, 5'd0, 5'd9);
        push_exp(K_RBUSY_A, 1, 32'd0, "x9_busy_same_cycle");
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd9);
        push_exp(K_RBUSY_A, 1, 32'd1, "x9_busy");
        push_exp(K_HAZARD_A, 0, 32'd1, "x9_hazard");
        push_exp(K_RBUSY_B, 1, 32'd1, "x9_busy_b");
        tick();
        apply_stimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, 5'd0, 5'd9);
        push_exp(K_RBUSY_A, 1, 32'd0, "x9_busy_masked");
        push_exp(K_HAZARD_A, 0, 32'd0, "x9_hazard_masked");
        push_exp(K_RBUSY_B, 1, 32'd1, "x9_busy_unmasked_b");
        push_exp(K_HAZARD_B, 0, 32'd1, "x9_hazard_b");
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd9);
        push_exp(K_RBUSY_A, 1, 32'd0, "x9_busy_cleared");
        push_exp(K_RBUSY_B, 1, 32'd0, "x9_busy_cleared_b");
        push_exp(K_RDATA_A, 1, 32'h0000_0099, "x9_data");
        tick();

        // Issue and writeback of x3 together: data lands and busy stays set.
        apply_stimulus(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 5'd3, 5'd0);
        push_exp(K_RDATA_A, 0, 32'h0000_0033, "x3_bypass");
        push_exp(K_RDATA_B, 0, 32'd0, "x3_old_b");
        push_exp(K_RBUSY_A, 0, 32'd0, "x3_busy_before");
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd0, 5'd3, 5'd0);
        push_exp(K_RDATA_A, 0, 32'h0000_0033, "x3_written");
        push_exp(K_RBUSY_A, 0, 32'd1, "x3_issue_wins");
        push_exp(K_HAZARD_A, 0, 32'd1, "x3_hazard");
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd3);
        push_exp(K_RBUSY_A, 0, 32'd0, "x0_never_busy");
        push_exp(K_RDATA_A, 0, 32'd0, "x0_reads_zero");
        push_exp(K_RBUSY_A, 1, 32'd1, "x3_still_busy");
        tick();
        apply_stimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, '0, 5'd0, 5'd0);
        tick();

        // Reset in the middle of RUN with live data and a busy entry.
        apply_stimulus(1'b1, 5'd4, 32'h0000_0055, 1'b1, 5'd4, 5'd1, 5'd1);
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd1);
        push_exp(K_RDATA_A, 0, 32'h0000_0055, "x4_before_reset");
        push_exp(K_RBUSY_A, 0, 32'd1, "x4_busy_before_reset");
        tick();
        rst = 1'b1;
        push_exp(K_READY_A, 0, 32'd0, "ready_mid_reset");
        push_exp(K_RBUSY_A, 0, 32'd0, "x4_busy_in_reset");
        push_exp(K_RDATA_A, 0, 32'd0, "x4_rdata_in_reset");
        tick();
        rst = 1'b0;
        for (int n = 0; n < 32; n++) begin
            if (n == 0 || n == 31) begin
                push_exp(K_READY_A, 0, 32'd0, $sformatf("ready_resweep_%0d", n));
            end
            tick();
        end
        push_exp(K_READY_A, 0, 32'd1, "ready_after_resweep");
        push_exp(K_RDATA_A, 0, 32'd0, "x4_zeroed");
        push_exp(K_RBUSY_A, 0, 32'd0, "x4_busy_cleared");
        push_exp(K_HAZARD_A, 0, 32'd0, "hazard_after_resweep");
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
